// File: rtl/cpu_register_writeback_if.sv
// Producer/drain bundle for cpu_register_writeback: ALU and MEM handshakes, register-file write port,
// hazard mask, occupancy and the optional forwarding lookup.
interface cpu_register_writeback_if #(
  parameter int NUMBER_OF_REGISTERS = 16,
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 4
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                           flush_in;
  logic                           alu_valid_in;
  logic                           alu_ready_out;
  logic [AW-1:0]                  alu_address_in;
  logic [DATA_WIDTH-1:0]          alu_data_in;
  logic                           mem_valid_in;
  logic                           mem_ready_out;
  logic [AW-1:0]                  mem_address_in;
  logic [DATA_WIDTH-1:0]          mem_data_in;
  logic                           rf_write_enable_out;
  logic [AW-1:0]                  rf_write_address_out;
  logic [DATA_WIDTH-1:0]          rf_write_data_out;
  logic [NUMBER_OF_REGISTERS-1:0] pending_mask_out;
  logic [CW-1:0]                  count_out;
  logic [AW-1:0]                  query_address_in;
  logic                           forward_hit_out;
  logic [DATA_WIDTH-1:0]          forward_data_out;

  modport master (
    output flush_in, alu_valid_in, alu_address_in, alu_data_in,
           mem_valid_in, mem_address_in, mem_data_in, query_address_in,
    input  alu_ready_out, mem_ready_out, rf_write_enable_out, rf_write_address_out,
           rf_write_data_out, pending_mask_out, count_out, forward_hit_out, forward_data_out
  );

  modport slave (
    input  flush_in, alu_valid_in, alu_address_in, alu_data_in,
           mem_valid_in, mem_address_in, mem_data_in, query_address_in,
    output alu_ready_out, mem_ready_out, rf_write_enable_out, rf_write_address_out,
           rf_write_data_out, pending_mask_out, count_out, forward_hit_out, forward_data_out
  );
endinterface

// File: rtl/cpu_register_writeback.sv
// Two-source round-robin writeback buffer draining one entry per cycle into the register file.
// Define CPU_WB_FORWARD_EN to build the newest-entry forwarding lookup.
module cpu_register_writeback #(
    parameter int NUMBER_OF_REGISTERS = 16,
    parameter int DATA_WIDTH          = 8,
    parameter int FIFO_DEPTH          = 4
) (
    input logic                      clock_in,
    input logic                      reset_n_in,
    cpu_register_writeback_if.slave  wb
);
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic { PRIO_ALU = 1'b0, PRIO_MEM = 1'b1 } prio_e;

    logic [AW-1:0]         addr_q [FIFO_DEPTH];
    logic [AW-1:0]         addr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    prio_e                 prio_q, prio_d;

    logic                  grant_alu, grant_mem, has_room, alu_ready, mem_ready;
    logic                  take, push, pop;
    logic [AW-1:0]         take_addr;
    logic [DATA_WIDTH-1:0] take_data;

    always_comb begin
        has_room  = count_q < CW'(FIFO_DEPTH);
        grant_alu = wb.alu_valid_in && (!wb.mem_valid_in || prio_q == PRIO_ALU);
        grant_mem = wb.mem_valid_in && !grant_alu;
        // Gating with reset keeps ready low during reset even though an empty FIFO has room.
        alu_ready = reset_n_in && !wb.flush_in && has_room && grant_alu;
        mem_ready = reset_n_in && !wb.flush_in && has_room && grant_mem;
        take      = alu_ready || mem_ready;
        take_addr = alu_ready ? wb.alu_address_in : wb.mem_address_in;
        take_data = alu_ready ? wb.alu_data_in    : wb.mem_data_in;
        push      = take && (take_addr != '0);
        pop       = (count_q != '0) && !wb.flush_in;

        prio_d = prio_q;
        if (take && wb.alu_valid_in && wb.mem_valid_in)
            prio_d = (prio_q == PRIO_ALU) ? PRIO_MEM : PRIO_ALU;

        addr_d = addr_q;
        data_d = data_q;
        if (push) begin
            addr_d[wr_ptr_q] = take_addr;
            data_d[wr_ptr_q] = take_data;
        end

        if (wb.flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= PRIO_ALU;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; count_q alone defines which slots are valid.
    always_ff @(posedge clock_in) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_comb begin
        wb.alu_ready_out        = alu_ready;
        wb.mem_ready_out        = mem_ready;
        wb.count_out            = count_q;
        wb.rf_write_enable_out  = count_q != '0;
        wb.rf_write_address_out = wb.rf_write_enable_out ? addr_q[rd_ptr_q] : '0;
        wb.rf_write_data_out    = wb.rf_write_enable_out ? data_q[rd_ptr_q] : '0;
    end

    always_comb begin
        logic [PW-1:0] idx;
        wb.pending_mask_out = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) wb.pending_mask_out[addr_q[idx]] = 1'b1;
        end
        wb.pending_mask_out[0] = 1'b0;
    end

`ifdef CPU_WB_FORWARD_EN
    // Scan oldest to newest so the last match found is the newest entry.
    always_comb begin
        logic [PW-1:0] idx;
        wb.forward_hit_out  = 1'b0;
        wb.forward_data_out = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q && wb.query_address_in != '0 &&
                addr_q[idx] == wb.query_address_in) begin
                wb.forward_hit_out  = 1'b1;
                wb.forward_data_out = data_q[idx];
            end
        end
    end
`else
    logic unused_query_address;
    assign unused_query_address = ^wb.query_address_in;
    assign wb.forward_hit_out   = 1'b0;
    assign wb.forward_data_out  = '0;
`endif
endmodule

// File: tb/tb_cpu_register_writeback.sv
// Randomised + directed bench for cpu_register_writeback against a queue-based reference model.
module tb_cpu_register_writeback;
  localparam int NREG = 16;
  localparam int DW   = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  wr_t  model_q[$];
  bit   model_prio_mem = 1'b0;

  cpu_register_writeback_if #(.NUMBER_OF_REGISTERS(NREG), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) wb ();

  cpu_register_writeback #(.NUMBER_OF_REGISTERS(NREG), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .wb         (wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wb.flush_in = 1'b0;
    wb.alu_valid_in = 1'b0; wb.alu_address_in = '0; wb.alu_data_in = '0;
    wb.mem_valid_in = 1'b0; wb.mem_address_in = '0; wb.mem_data_in = '0;
  endtask

  // Compare every output against the model; called mid-cycle with inputs stable.
  task automatic check_outputs(input bit av, input bit mv, input bit fl);
    logic [NREG-1:0] mask;
    bit exp_ar, exp_mr, hit;
    logic [DW-1:0] fdata;
    int sz;
    sz = model_q.size();
    mask = '0;
    foreach (model_q[i]) mask[model_q[i].a] = 1'b1;
    mask[0] = 1'b0;
    // The winner is the sole valid source, or the priority holder under contention.
    exp_ar = rst_n && !fl && sz < DEPTH && av && !(mv && model_prio_mem);
    exp_mr = rst_n && !fl && sz < DEPTH && mv && !(av && !model_prio_mem);
    check("alu_ready", 64'(wb.alu_ready_out), 64'(exp_ar));
    check("mem_ready", 64'(wb.mem_ready_out), 64'(exp_mr));
    check("count",     64'(wb.count_out), 64'(sz));
    check("rf_we",     64'(wb.rf_write_enable_out), 64'(sz > 0));
    check("rf_addr",   64'(wb.rf_write_address_out), sz > 0 ? 64'(model_q[0].a) : 64'd0);
    check("rf_data",   64'(wb.rf_write_data_out), sz > 0 ? 64'(model_q[0].d) : 64'd0);
    check("pending",   64'(wb.pending_mask_out), 64'(mask));
    hit = 1'b0; fdata = '0;
`ifdef CPU_WB_FORWARD_EN
    foreach (model_q[i])
      if (model_q[i].a == wb.query_address_in && wb.query_address_in != 0) begin
        hit = 1'b1; fdata = model_q[i].d;
      end
`endif
    check("fwd_hit",  64'(wb.forward_hit_out), 64'(hit));
    check("fwd_data", 64'(wb.forward_data_out), 64'(fdata));
  endtask

  task automatic step(input bit av, input logic [3:0] aa, input logic [DW-1:0] ad,
                      input bit mv, input logic [3:0] ma, input logic [DW-1:0] md,
                      input bit fl, input logic [3:0] qa);
    bit alu_xfer, mem_xfer;
    wr_t e;
    @(negedge clk);
    wb.alu_valid_in = av; wb.alu_address_in = aa; wb.alu_data_in = ad;
    wb.mem_valid_in = mv; wb.mem_address_in = ma; wb.mem_data_in = md;
    wb.flush_in = fl; wb.query_address_in = qa;
    #1;
    check_outputs(av, mv, fl);
    alu_xfer = !fl && model_q.size() < DEPTH && av && !(mv && model_prio_mem);
    mem_xfer = !fl && model_q.size() < DEPTH && mv && !(av && !model_prio_mem);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      if (alu_xfer && aa != 0) begin e.a = aa; e.d = ad; model_q.push_back(e); end
      if (mem_xfer && ma != 0) begin e.a = ma; e.d = md; model_q.push_back(e); end
    end
    if ((alu_xfer || mem_xfer) && av && mv) model_prio_mem = !model_prio_mem;
  endtask

  task automatic async_reset_check();
    #2;
    drive_idle();
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_prio_mem = 1'b0;
    check("async_rf_we", 64'(wb.rf_write_enable_out), 64'd0);
    check("async_count", 64'(wb.count_out), 64'd0);
    check("async_pend",  64'(wb.pending_mask_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive_idle();
    wb.query_address_in = '0;
    // Valid sources during reset must still see every output low.
    wb.alu_valid_in = 1'b1; wb.alu_address_in = 4'd5;
    wb.mem_valid_in = 1'b1; wb.mem_address_in = 4'd6;
    #12;
    check_outputs(1'b1, 1'b1, 1'b0);
    check("rst_alu_ready", 64'(wb.alu_ready_out), 64'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 4'd3, 8'(-5), 0, 0, 0, 0, 4'd3);
    step(0, 0, 0, 0, 0, 0, 0, 4'd3);
    check("first_latency_data", 64'(model_q.size()), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 4'd3);

    for (int i = 0; i < 4; i++)
      step(1, 4'd1, 8'(10 + i), 1, 4'd2, 8'(20 + i), 0, 4'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++)
      step(1, 4'(7 + i), 8'(30 + i), 1, 4'd12, 8'(50 + i), 0, 4'd12);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    step(1, 4'd0, 8'd7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    step(1, 4'd4, 8'd44, 0, 0, 0, 0, 4'd4);
    step(1, 4'd5, 8'd55, 0, 0, 0, 0, 4'd5);
    step(1, 4'd6, 8'd66, 1, 4'd7, 8'd77, 1, 4'd5);
    step(0, 0, 0, 0, 0, 0, 0, 4'd5);

    step(1, 4'd6, 8'd66, 0, 0, 0, 0, 4'd6);
    async_reset_check();
    step(0, 0, 0, 0, 0, 0, 0, 4'd6);

    step(1, 4'd9, 8'd3, 0, 0, 0, 0, 4'd9);
    step(0, 0, 0, 1, 4'd9, 8'(-2), 0, 4'd9);
    step(0, 0, 0, 0, 0, 0, 0, 4'd9);
    step(0, 0, 0, 0, 0, 0, 0, 4'd0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] aa, ma, qa;
      aa = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      ma = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      qa = 4'($urandom);
      step($urandom_range(0, 2) != 0, aa, 8'($urandom),
           $urandom_range(0, 2) != 0, ma, 8'($urandom),
           $urandom_range(0, 19) == 0, qa);
      if (i == 200) async_reset_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
